// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin N-to-1 mux.
package mux_pkg;

   localparam int DEFAULT_WIDTH    = 8;
   localparam int DEFAULT_CHANNELS = 4;
   localparam int MAX_CHANNELS     = 16;
   localparam int MAX_SEL_W        = 4;

   // Lane index wide enough for the largest legal channel count.
   typedef logic [MAX_SEL_W-1:0] lane_idx_t;

   // Increment a lane index, wrapping explicitly at n so that
   // non-power-of-2 channel counts never reach an unused index.
   function automatic lane_idx_t next_idx(input lane_idx_t idx, input int unsigned n);
      if (32'(idx) + 32'd1 >= n) return '0;
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// First-valid search starting at ptr and wrapping modulo CHANNELS.
// Used only by the work-conserving (skip-idle) build of mux_nx1_rr.
module rr_pick
   import mux_pkg::*;
#(
   parameter int CHANNELS = DEFAULT_CHANNELS,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] valid_in,
   input  logic [SEL_W-1:0]    ptr,
   output logic [SEL_W-1:0]    grant,
   output logic                any_valid
);

   int idx;

   // Walk the offsets from farthest to nearest so the lane closest
   // to ptr (in rotation order) is the last writer and wins.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      idx       = 0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % CHANNELS;
         if (valid_in[idx]) begin
            grant     = SEL_W'(idx);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_nx1_rr.sv
// Registered N-to-1 round-robin mux with stall and channel tag.
// Build option: define MUX_NX1_SKIP_IDLE_EN for work-conserving
// skip-idle arbitration; otherwise fixed TDM rotation, one slot per lane.
module mux_nx1_rr
   import mux_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int CHANNELS = DEFAULT_CHANNELS,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic [CHANNELS-1:0]       valid_in,
   input  logic                      stall,
   output logic [WIDTH-1:0]          data_out,
   output logic                      valid_out,
   output logic [SEL_W-1:0]          chan_out
);

   logic [CHANNELS-1:0][WIDTH-1:0] lanes;
   logic [SEL_W-1:0]               ptr;
   logic [SEL_W-1:0]               sel;
   logic [SEL_W-1:0]               ptr_nxt;

   assign lanes = data_in;

   function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
      return SEL_W'(next_idx(lane_idx_t'(i), CHANNELS));
   endfunction

`ifdef MUX_NX1_SKIP_IDLE_EN
   logic [SEL_W-1:0] pick_grant;
   logic             pick_any;

   rr_pick #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_pick (
      .valid_in  (valid_in),
      .ptr       (ptr),
      .grant     (pick_grant),
      .any_valid (pick_any)
   );

   // With nothing valid, report the pointer slot and leave it in place.
   assign sel     = pick_any ? pick_grant : ptr;
   assign ptr_nxt = pick_any ? wrap_inc(pick_grant) : ptr;
`else
   // Fixed rotation: every lane owns a slot whether or not it is valid.
   assign sel     = ptr;
   assign ptr_nxt = wrap_inc(ptr);
`endif

   // Pointer and output registers; stall freezes everything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         chan_out  <= '0;
      end else if (!stall) begin
         ptr       <= ptr_nxt;
         valid_out <= valid_in[sel];
         data_out  <= valid_in[sel] ? lanes[sel] : '0;
         chan_out  <= sel;
      end
   end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-to-1 registered multiplexer that serialises CHANNELS valid-qualified input lanes onto one output lane with a round-robin channel pointer. It generalises the fixed 2-to-1 alternating mux with configurable width and channel count, a stall input, a channel tag on the output, and an optional work-conserving mode. It sits in the datapath between parallel lane producers and a single downstream consumer.

## Interface
Parameters:
- WIDTH, 8, data width per lane.
- CHANNELS, 4, number of input lanes; legal range 2..16.
- SEL_W, $clog2(CHANNELS), width of channel index; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  CHANNELS*WIDTH  packed lanes; lane k at bits [k*WIDTH +: WIDTH].
- valid_in  input  CHANNELS  per-lane valid.
- stall  input  1  downstream hold; when 1, all state and outputs freeze.
- data_out  output  WIDTH  registered selected data.
- valid_out  output  1  registered valid for data_out.
- chan_out  output  SEL_W  registered index of the lane sampled into data_out.

## Operation
- Internal state: pointer ptr (SEL_W bits), the next lane to serve.
- Each cycle with stall=0, a lane g is chosen (mode below), then registered: data_out<=valid_in[g]?lane g:0, valid_out<=valid_in[g], chan_out<=g.
- data_out is forced to 0 whenever valid_out is 0; no stale data is ever presented.
- Default mode (TDM): g=ptr regardless of valid; ptr<=ptr+1, wrapping from CHANNELS-1 to 0 (non-power-of-2 CHANNELS wrap explicitly, never visit indices ≥CHANNELS).
- Skip-idle mode (see Configuration): g = first k in ptr, ptr+1, … (mod CHANNELS) with valid_in[k]=1; ptr<=g+1 mod CHANNELS. If no lane is valid: valid_out<=0, data_out<=0, chan_out<=ptr, ptr unchanged.
- stall=1: ptr, data_out, valid_out, chan_out hold; inputs ignored that cycle.
- reset asserted (0) at any time, including mid-rotation: immediately ptr=0, data_out=0, valid_out=0, chan_out=0; held while reset=0. First service after release is lane 0 (TDM) or the first valid lane from 0 (skip-idle).

## Timing
- Latency: one cycle from valid_in/data_in sample edge to data_out/valid_out/chan_out.
- Outputs are purely registered; no combinational input-to-output path.
- TDM throughput: each lane served exactly once every CHANNELS unstalled cycles.
- Skip-idle: at most CHANNELS-1 other grants between two grants to a continuously valid lane (fairness bound).
- Stall and reset deassertion take effect on the next rising edge; reset assertion is asynchronous.

## Configuration
- MUX_NX1_SKIP_IDLE_EN defined: skip-idle work-conserving arbitration as above.
- Undefined: TDM fixed rotation (one slot per lane, invalid slots emit valid_out=0, data_out=0).
- Interface is identical in both builds.

## Structure
- Shared package mux_pkg: default WIDTH/CHANNELS constants, lane-index typedef helper, wrap-increment function next_idx(idx, n).
- One sub-module: rr_pick — combinational first-set search over valid_in rotated by ptr, returning grant index and any_valid; instantiated only when MUX_NX1_SKIP_IDLE_EN is defined.
- Top holds ptr and output registers.

## Test plan
- Reset mid-stream: CHANNELS=4, run 5 cycles, pull reset low between edges -> outputs 0 and ptr=0 immediately; after release first chan_out=0.
- TDM all valid: lanes = 0x11,0x22,0x33,0x44, valid_in=4'b1111 -> data_out cycles 0x11,0x22,0x33,0x44,0x11 with chan_out 0,1,2,3,0, valid_out=1.
- TDM sparse: valid_in=4'b0101 -> valid_out pattern 1,0,1,0; invalid slots have data_out=0x00.
- Skip-idle sparse: valid_in=4'b1010 -> chan_out 1,3,1,3, valid_out=1 every cycle; valid_in=0 -> valid_out=0, ptr held.
- Stall: assert stall for 3 cycles mid-rotation -> outputs and chan_out constant; rotation resumes at the same next lane.
- Non-power-of-2: CHANNELS=3, WIDTH=16, all valid -> chan_out 0,1,2,0; never 3.
